// File: rtl/utmi_tx_sequencer_if.sv
// Requester-side byte-stream handshake of the UTMI TX sequencer.
// Two requesters share the bundle, one byte lane each (req n on reqData[8n+7:8n]).
interface utmi_tx_sequencer_if;
    logic [1:0]  reqValid;
    logic [15:0] reqData;
    logic [1:0]  reqLast;
    logic [1:0]  reqReady;
    logic [1:0]  gnt;

    modport master (
        output reqValid, reqData, reqLast,
        input  reqReady, gnt
    );

    modport slave (
        input  reqValid, reqData, reqLast,
        output reqReady, gnt
    );
endinterface

// File: rtl/utmi_tx_sequencer.sv
// UTMI transmit sequencer: arbitrates whole packets from two byte-stream requesters,
// streams them to the PHY, enforces an inter-packet gap and aborts on underrun or TxReady timeout.
module utmi_tx_sequencer #(
    parameter int unsigned IPG_CYCLES = 4,
    parameter int unsigned TXREADY_TO = 16
) (
    input  logic                      phy_clk_pad_i,
    input  logic                      rst_i,
    utmi_tx_sequencer_if.slave        req,
    output logic [7:0]                DataOut_pad_o,
    output logic                      TxValid_pad_o,
    input  logic                      TxReady_pad_i,
    input  logic                      RxActive_pad_i,
    output logic                      busy_o,
    output logic                      pkt_done_o,
    output logic                      underrun_o,
    output logic                      timeout_o
);

    localparam int unsigned GapLoad = (IPG_CYCLES == 0) ? 1 : IPG_CYCLES;
    localparam int unsigned GapW    = $clog2(GapLoad + 1);
    localparam int unsigned ToW     = (TXREADY_TO > 1) ? $clog2(TXREADY_TO) : 1;

    localparam logic [GapW-1:0] GapInit = GapW'(GapLoad);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TXREADY_TO - 1);

    typedef enum logic [1:0] {StIdle, StXmit, StGap} stateT;

    stateT            stateQ, stateD;
    logic [7:0]       holdQ, holdD;
    logic             holdLastQ, holdLastD;
    logic             gntQ, gntD;
    logic [ToW-1:0]   toCntQ, toCntD;
    logic [GapW-1:0]  gapCntQ, gapCntD;
    logic             txValidQ, txValidD;
    logic             pktDoneQ, pktDoneD;
    logic             underrunQ, underrunD;
    logic             timeoutQ, timeoutD;

    logic       sel;
    logic       start;
    logic       gntValid;
    logic       moreBytes;
    logic [7:0] selData;
    logic [7:0] gntData;

    // Fixed priority: requester 0 wins whenever it is valid.
    assign sel       = ~req.reqValid[0];
    assign selData   = sel ? req.reqData[15:8] : req.reqData[7:0];
    assign gntData   = gntQ ? req.reqData[15:8] : req.reqData[7:0];
    assign gntValid  = req.reqValid[gntQ];
    assign start     = (stateQ == StIdle) && (|req.reqValid) && !RxActive_pad_i
                       && (gapCntQ == '0);
    assign moreBytes = (stateQ == StXmit) && TxReady_pad_i && !holdLastQ && gntValid;

    always_ff @(posedge phy_clk_pad_i or posedge rst_i) begin
        if (rst_i) begin
            stateQ    <= StIdle;
            holdQ     <= '0;
            holdLastQ <= 1'b0;
            gntQ      <= 1'b0;
            toCntQ    <= '0;
            gapCntQ   <= '0;
            txValidQ  <= 1'b0;
            pktDoneQ  <= 1'b0;
            underrunQ <= 1'b0;
            timeoutQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            holdQ     <= holdD;
            holdLastQ <= holdLastD;
            gntQ      <= gntD;
            toCntQ    <= toCntD;
            gapCntQ   <= gapCntD;
            txValidQ  <= txValidD;
            pktDoneQ  <= pktDoneD;
            underrunQ <= underrunD;
            timeoutQ  <= timeoutD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        holdD     = holdQ;
        holdLastD = holdLastQ;
        gntD      = gntQ;
        toCntD    = toCntQ;
        gapCntD   = gapCntQ;
        txValidD  = txValidQ;
        pktDoneD  = 1'b0;
        underrunD = 1'b0;
        timeoutD  = 1'b0;

        unique case (stateQ)
            StIdle: begin
                // A gap left over from receive traffic drains here before any TX may start.
                if (RxActive_pad_i) begin
                    gapCntD = GapInit;
                end else if (gapCntQ != '0) begin
                    gapCntD = gapCntQ - 1'b1;
                end else if (start) begin
                    holdD     = selData;
                    holdLastD = req.reqLast[sel];
                    gntD      = sel;
                    txValidD  = 1'b1;
                    toCntD    = '0;
                    stateD    = StXmit;
                end
            end
            StXmit: begin
                if (TxReady_pad_i) begin
                    if (holdLastQ) begin
                        txValidD = 1'b0;
                        pktDoneD = 1'b1;
                        gapCntD  = GapInit;
                        stateD   = StGap;
                    end else if (gntValid) begin
                        holdD     = gntData;
                        holdLastD = req.reqLast[gntQ];
                        toCntD    = '0;
                    end else begin
                        underrunD = 1'b1;
                        txValidD  = 1'b0;
                        gapCntD   = GapInit;
                        stateD    = StGap;
                    end
                end else if (toCntQ == ToLast) begin
                    timeoutD = 1'b1;
                    txValidD = 1'b0;
                    gapCntD  = GapInit;
                    stateD   = StGap;
                end else begin
                    toCntD = toCntQ + 1'b1;
                end
            end
            StGap: begin
                if (RxActive_pad_i) begin
                    gapCntD = GapInit;
                end else if (gapCntQ <= GapW'(1)) begin
                    gapCntD = '0;
                    stateD  = StIdle;
                end else begin
                    gapCntD = gapCntQ - 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        req.reqReady = '0;
        req.gnt      = '0;
        if (stateQ == StXmit) begin
            req.gnt[gntQ] = 1'b1;
        end
        if (start) begin
            req.reqReady[sel] = 1'b1;
        end
        if (moreBytes) begin
            req.reqReady[gntQ] = 1'b1;
        end
        // The handshake is combinational, so keep it quiet while reset is held.
        if (rst_i) begin
            req.reqReady = '0;
        end
    end

    assign DataOut_pad_o = holdQ;
    assign TxValid_pad_o = txValidQ;
    assign busy_o        = (stateQ != StIdle);
    assign pkt_done_o    = pktDoneQ;
    assign underrun_o    = underrunQ;
    assign timeout_o     = timeoutQ;

endmodule
